// File: rtl/thor2024_regfile_tracker_pkg.sv
// Shared register-specifier and queue-id types plus default sizing for the
// Thor2024 register valid/source scoreboard.
package thor2024_regfile_tracker_pkg;

   localparam int AREGS    = 64;
   localparam int QENTRIES = 8;
   localparam int IDW      = $clog2(QENTRIES);
   localparam int RSW      = 6;

   typedef logic [RSW-1:0] regspec_t;
   typedef logic [IDW-1:0] qid_t;

endpackage

// File: rtl/thor2024_regfile_tracker_enq_tgt_resolve.sv
// Flags each enqueue slot whose target is overwritten by a younger slot in the
// same group; slot 0 is oldest. Purely combinational, shared with rename.
module thor2024_enq_tgt_resolve
   import thor2024_regfile_tracker_pkg::*;
#(
   parameter int ENQ_WIDTH = 2
) (
   input  logic     [ENQ_WIDTH-1:0] wr_i,
   input  regspec_t [ENQ_WIDTH-1:0] tgt_i,
   output logic     [ENQ_WIDTH-1:0] killed_o
);

   always_comb begin
      killed_o = '0;
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         for (int j = i + 1; j < ENQ_WIDTH; j++) begin
            if (wr_i[i] && wr_i[j] && (tgt_i[i] == tgt_i[j])) begin
               killed_o[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/thor2024_regfile_tracker.sv
// Per-register valid bit and producer-id scoreboard with flush, commit and enqueue.
// Define RF_VALID_FWD_EN to expose the combinational next-state valid on rf_v_fwd_o.
module thor2024_regfile_tracker #(
   parameter int  AREGS     = thor2024_regfile_tracker_pkg::AREGS,
   parameter int  QENTRIES  = thor2024_regfile_tracker_pkg::QENTRIES,
   parameter int  ENQ_WIDTH = 2,
   parameter int  CMT_WIDTH = 2,
   localparam int IDW       = $clog2(QENTRIES),
   localparam int BCW       = $clog2(AREGS) + 1
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             flush_i,
   input  logic [AREGS-1:0]                                 livetarget_i,
   input  logic [ENQ_WIDTH-1:0]                             enq_v_i,
   input  logic [ENQ_WIDTH-1:0]                             enq_rfw_i,
   input  thor2024_regfile_tracker_pkg::regspec_t [ENQ_WIDTH-1:0] enq_tgt_i,
   input  logic [ENQ_WIDTH-1:0][IDW-1:0]                    enq_id_i,
   input  logic [CMT_WIDTH-1:0]                             cmt_v_i,
   input  thor2024_regfile_tracker_pkg::regspec_t [CMT_WIDTH-1:0] cmt_tgt_i,
   input  logic [CMT_WIDTH-1:0][IDW-1:0]                    cmt_id_i,
   output logic [AREGS-1:0]                                 rf_v_o,
   output logic [AREGS-1:0][IDW-1:0]                        rf_source_o,
   output logic [AREGS-1:0]                                 rf_v_fwd_o,
   output logic [BCW-1:0]                                   busy_cnt_o
);

   import thor2024_regfile_tracker_pkg::*;

   logic [AREGS-1:0]          rfV_q, rfV_d;
   logic [AREGS-1:0][IDW-1:0] rfSrc_q, rfSrc_d;
   logic [BCW-1:0]            busyCnt_q, busyCnt_d;
   logic [ENQ_WIDTH-1:0]      enqWr;
   logic [ENQ_WIDTH-1:0]      enqKilled;

   // A branch miss squashes the whole enqueue group.
   assign enqWr = flush_i ? '0 : (enq_v_i & enq_rfw_i);

   thor2024_enq_tgt_resolve #(
      .ENQ_WIDTH (ENQ_WIDTH)
   ) u_enq_tgt_resolve (
      .wr_i     (enqWr),
      .tgt_i    (enq_tgt_i),
      .killed_o (enqKilled)
   );

   // Flush, then commit, then enqueue; each later step overrides the earlier ones.
   always_comb begin
      rfV_d   = rfV_q;
      rfSrc_d = rfSrc_q;
      for (int r = 0; r < AREGS; r++) begin
         if (flush_i && !rfV_q[r] && !livetarget_i[r]) begin
            rfV_d[r] = 1'b1;
         end
      end
      for (int r = 1; r < AREGS; r++) begin
         for (int s = 0; s < CMT_WIDTH; s++) begin
            if (cmt_v_i[s] && (cmt_tgt_i[s] == RSW'(r)) && !rfV_q[r] &&
                (rfSrc_q[r] == cmt_id_i[s])) begin
               rfV_d[r] = 1'b1;
            end
         end
         for (int s = 0; s < ENQ_WIDTH; s++) begin
            if (enqWr[s] && !enqKilled[s] && (enq_tgt_i[s] == RSW'(r))) begin
               rfV_d[r]   = 1'b0;
               rfSrc_d[r] = enq_id_i[s];
            end
         end
      end
      rfV_d[0]   = 1'b1;
      rfSrc_d[0] = '0;
   end

   always_comb begin
      busyCnt_d = '0;
      for (int r = 0; r < AREGS; r++) begin
         busyCnt_d = busyCnt_d + BCW'(!rfV_d[r]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rfV_q     <= '1;
         rfSrc_q   <= '0;
         busyCnt_q <= '0;
      end else begin
         rfV_q     <= rfV_d;
         rfSrc_q   <= rfSrc_d;
         busyCnt_q <= busyCnt_d;
      end
   end

   assign rf_v_o      = rfV_q;
   assign rf_source_o = rfSrc_q;
   assign busy_cnt_o  = busyCnt_q;

`ifdef RF_VALID_FWD_EN
   assign rf_v_fwd_o = rfV_d;
`else
   assign rf_v_fwd_o = rfV_q;
`endif

endmodule

// File: tb/tb_thor2024_regfile_tracker.sv
// Randomized and directed bench for the register valid/source scoreboard,
// checked each cycle against a per-register behavioural model.
module tb_thor2024_regfile_tracker;
   import thor2024_regfile_tracker_pkg::*;

   localparam int NA = 64;
   localparam int EW = 2;
   localparam int CW = 2;
   localparam int IW = 3;
   localparam int BW = 7;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   flush;
   logic [NA-1:0]          livetarget;
   logic [EW-1:0]          enqV, enqRfw;
   regspec_t [EW-1:0]      enqTgt;
   logic [EW-1:0][IW-1:0]  enqId;
   logic [CW-1:0]          cmtV;
   regspec_t [CW-1:0]      cmtTgt;
   logic [CW-1:0][IW-1:0]  cmtId;
   logic [NA-1:0]          rfV;
   logic [NA-1:0][IW-1:0]  rfSource;
   logic [NA-1:0]          rfVFwd;
   logic [BW-1:0]          busyCnt;

   bit mV[NA];
   int mS[NA];
   bit nV[NA];
   int nS[NA];
   int checks = 0;
   int errors = 0;

   thor2024_regfile_tracker dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .livetarget_i (livetarget),
      .enq_v_i      (enqV),
      .enq_rfw_i    (enqRfw),
      .enq_tgt_i    (enqTgt),
      .enq_id_i     (enqId),
      .cmt_v_i      (cmtV),
      .cmt_tgt_i    (cmtTgt),
      .cmt_id_i     (cmtId),
      .rf_v_o       (rfV),
      .rf_source_o  (rfSource),
      .rf_v_fwd_o   (rfVFwd),
      .busy_cnt_o   (busyCnt)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void modelReset();
      for (int r = 0; r < NA; r++) begin
         mV[r] = 1'b1;
         mS[r] = 0;
      end
   endfunction

   // Scoreboard rules: flush releases dead targets, matching commits validate, enqueue claims.
   function automatic void modelNext();
      for (int r = 0; r < NA; r++) begin
         nV[r] = mV[r];
         nS[r] = mS[r];
      end
      if (flush) begin
         for (int r = 0; r < NA; r++)
            if (!mV[r] && !livetarget[r]) nV[r] = 1'b1;
      end
      for (int s = 0; s < CW; s++) begin
         int t = int'(cmtTgt[s]);
         if (cmtV[s] && t != 0 && !mV[t] && mS[t] == int'(cmtId[s])) nV[t] = 1'b1;
      end
      if (!flush) begin
         for (int s = 0; s < EW; s++) begin
            int t = int'(enqTgt[s]);
            if (enqV[s] && enqRfw[s] && t != 0) begin
               nV[t] = 1'b0;
               nS[t] = int'(enqId[s]);
            end
         end
      end
   endfunction

   task automatic clearInputs();
      flush      = 1'b0;
      livetarget = '0;
      enqV       = '0;
      enqRfw     = '0;
      enqTgt     = '0;
      enqId      = '0;
      cmtV       = '0;
      cmtTgt     = '0;
      cmtId      = '0;
   endtask

   task automatic setEnq(input int s, input int tgt, input int id);
      enqV[s]   = 1'b1;
      enqRfw[s] = 1'b1;
      enqTgt[s] = 6'(tgt);
      enqId[s]  = 3'(id);
   endtask

   task automatic setCmt(input int s, input int tgt, input int id);
      cmtV[s]   = 1'b1;
      cmtTgt[s] = 6'(tgt);
      cmtId[s]  = 3'(id);
   endtask

   task automatic checkOutput();
      logic [NA-1:0] ev;
      int cnt;
      cnt = 0;
      for (int r = 0; r < NA; r++) begin
         ev[r] = mV[r];
         cnt += mV[r] ? 0 : 1;
      end
      checkVal("rf_v", rfV, ev);
      checkVal("busy_cnt", busyCnt, 64'(cnt));
      for (int r = 0; r < NA; r++)
         if (!mV[r]) checkVal($sformatf("rf_source[%0d]", r), 64'(rfSource[r]), 64'(mS[r]));
   endtask

   // Called at a negedge with inputs set; returns at the following negedge.
   task automatic applyStimulus();
      logic [NA-1:0] fv;
      modelNext();
      #1;
      for (int r = 0; r < NA; r++) begin
`ifdef RF_VALID_FWD_EN
         fv[r] = nV[r];
`else
         fv[r] = mV[r];
`endif
      end
      checkVal("rf_v_fwd", rfVFwd, fv);
      @(posedge clk);
      #1;
      for (int r = 0; r < NA; r++) begin
         mV[r] = nV[r];
         mS[r] = nS[r];
      end
      checkOutput();
      @(negedge clk);
   endtask

   task automatic randomInputs();
      clearInputs();
      flush      = ($urandom_range(0, 9) == 0);
      livetarget = {$urandom, $urandom};
      for (int s = 0; s < EW; s++) begin
         enqV[s]   = 1'($urandom_range(0, 1));
         enqRfw[s] = ($urandom_range(0, 3) != 0);
         enqTgt[s] = 6'($urandom_range(0, 15));
         enqId[s]  = 3'($urandom_range(0, 7));
      end
      for (int s = 0; s < CW; s++) begin
         int r;
         r         = $urandom_range(0, 15);
         cmtV[s]   = 1'($urandom_range(0, 1));
         cmtTgt[s] = 6'(r);
         cmtId[s]  = ($urandom_range(0, 3) != 0) ? 3'(mS[r]) : 3'($urandom_range(0, 7));
      end
   endtask

   initial begin
      rst = 1'b1;
      clearInputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      modelReset();
      checkOutput();
      checkVal("reset rf_v", rfV, {NA{1'b1}});
      checkVal("reset busy_cnt", busyCnt, 64'd0);

      setEnq(0, 5, 3);
      applyStimulus();
      checkVal("t1 rf_v[5]", rfV[5], 1'b0);
      checkVal("t1 rf_source[5]", rfSource[5], 3'd3);
      checkVal("t1 busy_cnt", busyCnt, 64'd1);

      clearInputs();
      setEnq(0, 7, 1);
      setEnq(1, 7, 2);
      applyStimulus();
      checkVal("t2 rf_source[7]", rfSource[7], 3'd2);
      clearInputs();
      setCmt(0, 7, 1);
      applyStimulus();
      checkVal("t2 stale commit rf_v[7]", rfV[7], 1'b0);
      clearInputs();
      setCmt(0, 7, 2);
      applyStimulus();
      checkVal("t2 commit rf_v[7]", rfV[7], 1'b1);

      clearInputs();
      setEnq(0, 4, 0);
      setEnq(1, 9, 1);
      applyStimulus();
      clearInputs();
      flush         = 1'b1;
      livetarget[9] = 1'b1;
      setEnq(0, 12, 4);
      applyStimulus();
      checkVal("t3 rf_v[4]", rfV[4], 1'b1);
      checkVal("t3 rf_v[9]", rfV[9], 1'b0);
      checkVal("t3 rf_v[12]", rfV[12], 1'b1);

      clearInputs();
      setEnq(0, 6, 2);
      applyStimulus();
      clearInputs();
      setCmt(0, 6, 2);
      setEnq(0, 6, 5);
      applyStimulus();
      checkVal("t4 rf_v[6]", rfV[6], 1'b0);
      checkVal("t4 rf_source[6]", rfSource[6], 3'd5);

      checkVal("t5 busy before", busyCnt, 64'd2);
      clearInputs();
      setEnq(0, 0, 6);
      applyStimulus();
      checkVal("t5 rf_v[0]", rfV[0], 1'b1);
      checkVal("t5 rf_source[0]", rfSource[0], 3'd0);
      checkVal("t5 busy after", busyCnt, 64'd2);

      clearInputs();
      setEnq(0, 5, 3);
      applyStimulus();
      clearInputs();
      setCmt(0, 5, 3);
      #1;
`ifdef RF_VALID_FWD_EN
      checkVal("t6 rf_v_fwd[5] same cycle", rfVFwd[5], 1'b1);
`else
      checkVal("t6 rf_v_fwd[5] same cycle", rfVFwd[5], 1'b0);
`endif
      checkVal("t6 rf_v[5] same cycle", rfV[5], 1'b0);
      applyStimulus();
      checkVal("t6 rf_v[5] next cycle", rfV[5], 1'b1);
      checkVal("t6 rf_v_fwd[5] next cycle", rfVFwd[5], 1'b1);

      for (int i = 0; i < 400; i++) begin
         randomInputs();
         applyStimulus();
      end

      randomInputs();
      #2;
      rst = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      checkOutput();
      checkVal("mid reset rf_v", rfV, {NA{1'b1}});
      checkVal("mid reset busy_cnt", busyCnt, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      clearInputs();
      for (int i = 0; i < 50; i++) begin
         randomInputs();
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
